// File: rtl/fsm_down_counter_if.sv
// Control/status bundle for the decade down-counter.
// The master drives load/enable/data; the counter (slave) returns count, borrow and error.
interface fsm_down_counter_if;
  logic       en;
  logic       load;
  logic [3:0] din;
  logic [3:0] cnt;
  logic       bout;
  logic       err;

  modport master (output en, load, din, input cnt, bout, err);
  modport slave  (input en, load, din, output cnt, bout, err);
endinterface

// File: rtl/fsm_down_counter.sv
// Decade (9..0) down-counter FSM with load, enable and a registered borrow/error pair.
// Build option FSM_DOWN_ONESHOT_EN: S0 becomes terminal and bout turns into a sticky done flag.
module fsm_down_counter (
  input  logic                clk,
  input  logic                rst,
  fsm_down_counter_if.slave   bus
);

  localparam int unsigned           CNT_W  = 4;
  localparam logic [CNT_W-1:0]      RELOAD = 4'd9;

  typedef enum logic [CNT_W-1:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9
  } state_e;

  // Raw vector rather than state_e so that upset codes 10..15 are representable and recoverable.
  logic [CNT_W-1:0] state_q, state_d;
  logic             bout_q, bout_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
`ifdef FSM_DOWN_ONESHOT_EN
    bout_d  = bout_q;
`else
    bout_d  = 1'b0;
`endif
    if (bus.load) begin
      bout_d = 1'b0;
      if (bus.din > RELOAD) begin
        state_d = RELOAD;
        err_d   = 1'b1;
      end else begin
        state_d = bus.din;
      end
    end else if (state_q > RELOAD) begin
      state_d = S0;
      bout_d  = 1'b0;
    end else if (bus.en) begin
`ifdef FSM_DOWN_ONESHOT_EN
      if (state_q == S1) begin
        state_d = S0;
        bout_d  = 1'b1;
      end else if (state_q != S0) begin
        state_d = state_q - 4'd1;
      end
`else
      if (state_q == S0) begin
        state_d = RELOAD;
        bout_d  = 1'b1;
      end else begin
        state_d = state_q - 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
    end
  end

  assign bus.cnt  = state_q;
  assign bus.bout = bout_q;
  assign bus.err  = err_q;

endmodule
